hilo_ctrl: RTL

HI/LO controller for the MIPS-54 CPU. It sequences the shared multiplier and divider units for MULT, MULTU, DIV and DIVU, and applies the unsigned and signed corrections to their results. It owns the HI and LO registers, serves MTHI, MTLO, MFHI and MFLO, and stalls the pipeline while an operation is in flight. It sits beside the EX stage, between decode and the two arithmetic units.

---
 rtl/hilo_pkg.sv | 21 ++
 rtl/hilo_if.sv | 23 ++
 rtl/hilo_sign_fix.sv | 20 ++
 rtl/hilo_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared widths, op encodings, FSM states and operand helpers for the HI/LO controller.
package hilo_pkg;
  localparam int XLEN = 32;
  localparam int DLEN = 64;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIX} state_t;
  function automatic logic is_mul(input logic [2:0] o);
    return o == OP_MULT || o == OP_MULTU;
  endfunction
  function automatic logic is_div(input logic [2:0] o);
    return o == OP_DIV || o == OP_DIVU;
  endfunction
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction
endpackage

// File: rtl/hilo_if.sv
// hilo_if: request/response bus between the HI/LO controller (master) and the shared multiplier/divider (slave).
interface hilo_if;
  import hilo_pkg::*;
  logic            mul_start;
  logic [XLEN-1:0] mul_a;
  logic [XLEN-1:0] mul_b;
  logic            mul_busy;
  logic [DLEN-1:0] mul_res;
  logic            div_start;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic            div_busy;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] div_r;
  modport master (
    output mul_start, mul_a, mul_b, div_start, div_dividend, div_divisor,
    input  mul_busy, mul_res, div_busy, div_q, div_r
  );
  modport slave (
    input  mul_start, mul_a, mul_b, div_start, div_dividend, div_divisor,
    output mul_busy, mul_res, div_busy, div_q, div_r
  );
endinterface

// File: rtl/hilo_sign_fix.sv
// hilo_sign_fix: turns raw signed-multiplier / unsigned-divider results into architectural HI/LO values.
module hilo_sign_fix import hilo_pkg::*; (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [DLEN-1:0] mul_res,
  input  logic [XLEN-1:0] div_q,
  input  logic [XLEN-1:0] div_r,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  logic [XLEN-1:0] multu_hi, q_s, r_s;
  always_comb begin
    multu_hi = mul_res[DLEN-1:XLEN] + (a[XLEN-1] ? b : '0) + (b[XLEN-1] ? a : '0);
    q_s      = (a[XLEN-1] ^ b[XLEN-1]) ? -div_q : div_q;
    r_s      = a[XLEN-1] ? -div_r : div_r;
    hi       = op == OP_MULT ? mul_res[DLEN-1:XLEN] : op == OP_MULTU ? multu_hi : op == OP_DIV ? r_s : div_r;
    lo       = is_mul(op) ? mul_res[XLEN-1:0] : op == OP_DIV ? q_s : div_q;
  end
endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: owns HI/LO, sequences MULT/MULTU/DIV/DIVU on the shared units and stalls the pipeline meanwhile.
// Define HILO_FWD_EN to bypass the value being written in FIX to MFHI/MFLO without stalling.
module hilo_ctrl import hilo_pkg::*; #(
  parameter int TIMEOUT_CYC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            mf_req,
  input  logic            mf_sel,
  output logic [XLEN-1:0] mf_data,
  output logic            stall,
  output logic            err,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  hilo_if.master          arith
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  state_t          state;
  logic [2:0]      op_r;
  logic [XLEN-1:0] a_r, b_r, fix_hi, fix_lo, new_hi, new_lo;
  logic [CW-1:0]   cnt;
  logic            div_zero, busy;
  hilo_sign_fix u_fix (
    .op      (op_r),
    .a       (a_r),
    .b       (b_r),
    .mul_res (arith.mul_res),
    .div_q   (arith.div_q),
    .div_r   (arith.div_r),
    .hi      (fix_hi),
    .lo      (fix_lo)
  );
  always_comb begin
    div_zero = is_div(op_r) && b_r == '0;
    busy     = is_mul(op_r) ? arith.mul_busy : arith.div_busy;
    new_hi   = div_zero ? a_r : fix_hi;
    new_lo   = div_zero ? '1 : fix_lo;
  end
`ifdef HILO_FWD_EN
  assign stall   = state != IDLE && (op_valid || (mf_req && state != FIX));
  assign mf_data = mf_sel ? (state == FIX ? new_hi : hi) : (state == FIX ? new_lo : lo);
`else
  assign stall   = state != IDLE && (op_valid || mf_req);
  assign mf_data = mf_sel ? hi : lo;
`endif
  // Operand outputs only change on acceptance: the multiplier re-reads them every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      op_r               <= '0;
      a_r                <= '0;
      b_r                <= '0;
      cnt                <= '0;
      hi                 <= '0;
      lo                 <= '0;
      err                <= 1'b0;
      arith.mul_start    <= 1'b0;
      arith.div_start    <= 1'b0;
      arith.mul_a        <= '0;
      arith.mul_b        <= '0;
      arith.div_dividend <= '0;
      arith.div_divisor  <= '0;
    end else begin
      case (state)
        IDLE: if (op_valid) begin
          if (op == OP_MTHI) hi <= rs_val;
          if (op == OP_MTLO) lo <= rs_val;
          if (is_mul(op) || is_div(op)) begin
            op_r <= op;
            a_r  <= rs_val;
            b_r  <= rt_val;
            cnt  <= '0;
            if (is_div(op) && rt_val == '0) state <= FIX;
            else if (is_mul(op)) begin
              state           <= ISSUE;
              arith.mul_a     <= rs_val;
              arith.mul_b     <= rt_val;
              arith.mul_start <= 1'b1;
            end else begin
              state              <= ISSUE;
              arith.div_dividend <= op == OP_DIV ? mag(rs_val) : rs_val;
              arith.div_divisor  <= op == OP_DIV ? mag(rt_val) : rt_val;
              arith.div_start    <= 1'b1;
            end
          end
        end
        ISSUE: if (busy) begin
          state           <= WAIT;
          arith.mul_start <= 1'b0;
          arith.div_start <= 1'b0;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          state           <= IDLE;
          err             <= 1'b1;
          arith.mul_start <= 1'b0;
          arith.div_start <= 1'b0;
        end else cnt <= cnt + 1'b1;
        WAIT: if (!busy) state <= FIX;
        FIX: begin
          state <= IDLE;
          hi    <= new_hi;
          lo    <= new_lo;
        end
      endcase
    end
  end
endmodule
